// File: rtl/narvie_link_pkg.sv
// Shared constants and state type for the host end of the UART instruction/regfile link.
package narvie_link_pkg;

    localparam int INSTR_BYTES          = 4;
    localparam int REGFILE_BYTES        = 128;
    localparam int REG_COUNT            = 32;
    localparam int UART_FRAME_BITS      = 10;
    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int DEFAULT_TIMEOUT_CLKS = 1200000;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RESP
    } link_state_t;

endpackage

// File: rtl/narvie_host_link_uart_rx_byte.sv
// UART 8N1 byte receiver: 2-FF synchroniser, half-bit start confirmation,
// mid-bit data sampling and stop-bit check. After a bad stop bit it waits for
// the line to return high before looking for another start edge.
module uart_rx_byte
    import narvie_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk12,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_strobe,
    output logic       frame_bad
);

    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_REARM
    } rx_state_t;

    rx_state_t     st;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    // Bring the asynchronous line into clk12 and keep one extra stage for edge detection.
    always_ff @(posedge clk12) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Frame reception: start confirm at half bit, then one sample per bit centre.
    always_ff @(posedge clk12) begin
        if (rst) begin
            st          <= RX_IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            data        <= '0;
            data_strobe <= 1'b0;
            frame_bad   <= 1'b0;
        end else begin
            data_strobe <= 1'b0;
            frame_bad   <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        st      <= RX_START;
                        clk_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        st      <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            st <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_sync) begin
                            data        <= shreg;
                            data_strobe <= 1'b1;
                            st          <= RX_IDLE;
                        end else begin
                            frame_bad <= 1'b1;
                            st        <= RX_REARM;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_REARM: begin
                    if (rx_sync) begin
                        st <= RX_IDLE;
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/narvie_host_link.sv
// Host end of the board link: serialises a 32-bit instruction as 4 UART bytes,
// then assembles the 128-byte register-file dump returned by the board.
module narvie_host_link
    import narvie_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
    input  logic          clk12,
    input  logic          rst,
    input  logic [31:0]   instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    output logic          tx,
    input  logic          rx,
    output logic [1023:0] regfile_out,
    output logic          regfile_valid,
    output logic          busy,
    output logic          timeout_err,
    output logic          frame_err
);

    localparam int            RF_BITS    = REG_COUNT * 32;
    localparam int            CW         = $clog2(CLKS_PER_BIT + 1);
    localparam int            TW         = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [3:0]    FRAME_LAST = 4'(UART_FRAME_BITS - 1);
    localparam logic [3:0]    STOP_NEXT  = 4'(UART_FRAME_BITS - 2);
    localparam logic [1:0]    TXB_LAST   = 2'(INSTR_BYTES - 1);
    localparam logic [6:0]    RXB_LAST   = 7'(REGFILE_BYTES - 1);

    link_state_t        state;
    logic [31:0]        instr_q;
    logic [CW-1:0]      clk_cnt;
    logic [3:0]         bit_idx;
    logic [1:0]         tx_byte;
    logic [6:0]         rx_cnt;
    logic [TW-1:0]      tmo_cnt;
    logic [RF_BITS-9:0] assembly;
    logic [7:0]         rx_data;
    logic               rx_strobe;
    logic               rx_frame_bad;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk12      (clk12),
        .rst        (rst),
        .rx         (rx),
        .data       (rx_data),
        .data_strobe(rx_strobe),
        .frame_bad  (rx_frame_bad)
    );

    // Link FSM: accept, TX serialisation, response collection and timeout.
    // Response bytes enter a shift register from the top, so after 127 shifts
    // byte k sits at [8k +: 8]; the final byte is spliced on directly.
    always_ff @(posedge clk12) begin
        if (rst) begin
            state         <= IDLE;
            instr_ready   <= 1'b0;
            busy          <= 1'b0;
            tx            <= 1'b1;
            instr_q       <= '0;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            tx_byte       <= '0;
            rx_cnt        <= '0;
            tmo_cnt       <= '0;
            assembly      <= '0;
            regfile_out   <= '0;
            regfile_valid <= 1'b0;
            timeout_err   <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            regfile_valid <= 1'b0;
            case (state)
                IDLE: begin
                    instr_ready <= 1'b1;
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        timeout_err <= 1'b0;
                        frame_err   <= 1'b0;
                        tx          <= 1'b0;
                        clk_cnt     <= '0;
                        bit_idx     <= '0;
                        tx_byte     <= '0;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (clk_cnt != BIT_LAST) begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end else begin
                        clk_cnt <= '0;
                        if (bit_idx == FRAME_LAST) begin
                            bit_idx <= '0;
                            if (tx_byte == TXB_LAST) begin
                                rx_cnt  <= '0;
                                tmo_cnt <= '0;
                                state   <= WAIT_RESP;
                            end else begin
                                tx_byte <= tx_byte + 1'b1;
                                instr_q <= {8'h00, instr_q[31:8]};
                                tx      <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= (bit_idx == STOP_NEXT) ? 1'b1 : instr_q[bit_idx[2:0]];
                        end
                    end
                end
                WAIT_RESP: begin
                    if (rx_strobe) begin
                        tmo_cnt <= '0;
                        if (rx_cnt == RXB_LAST) begin
                            regfile_out   <= {rx_data, assembly};
                            regfile_valid <= 1'b1;
                            instr_ready   <= 1'b1;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            assembly <= {rx_data, assembly[RF_BITS-9:8]};
                            rx_cnt   <= rx_cnt + 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    if (rx_frame_bad) begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_narvie_host_link.sv
// Self-checking bench for narvie_host_link: board-side UART model, TX decoder,
// table of transactions plus reset and held-request sequences.
module tb_narvie_host_link;

    localparam int CPB = 4;
    localparam int TMO = 200;

    logic          clk12 = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr = '0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic          tx;
    logic          rx = 1'b1;
    logic [1023:0] regfile_out;
    logic          regfile_valid;
    logic          busy;
    logic          timeout_err;
    logic          frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int acc_cnt = 0;
    int acc_seen = 0;
    bit prev_valid = 1'b0;
    logic [1023:0] model_rf = '0;
    logic [7:0] txq[$];
    int         txt[$];
    logic [7:0] mon_d;
    int         mon_st;

    typedef struct {
        logic [31:0] instr;
        int          n_good;
        int          bad_at;
        bit          pat_idx;
        bit          exp_done;
        bit          exp_ferr;
    } vec_t;
    vec_t vecs[5];

    narvie_host_link #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk12        (clk12),
        .rst          (rst),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .tx           (tx),
        .rx           (rx),
        .regfile_out  (regfile_out),
        .regfile_valid(regfile_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .frame_err    (frame_err)
    );

    always #5 clk12 = ~clk12;

    // Cycle counter used for timing expectations.
    always @(posedge clk12) cyc <= cyc + 1;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rf(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < 32; i++) begin
                if (act[32*i +: 32] !== exp[32*i +: 32]) begin
                    $display("FAIL %s: x%0d got %h expected %h", name, i, act[32*i +: 32], exp[32*i +: 32]);
                    break;
                end
            end
        end
    endtask

    // Decode bytes from tx by sampling bit centres; record each start cycle.
    always begin
        @(negedge clk12);
        if (tx === 1'b0) begin
            mon_st = cyc;
            repeat (CPB / 2) @(negedge clk12);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk12);
                mon_d[i] = tx;
            end
            repeat (CPB) @(negedge clk12);
            chk32("tx_stop_bit", tx, 1);
            txq.push_back(mon_d);
            txt.push_back(mon_st);
        end
    end

    // Watch the completion pulse: one cycle wide, busy already low, ready already high.
    always @(negedge clk12) begin
        if (regfile_valid) begin
            valid_cnt++;
            chk32("pulse_width", prev_valid, 0);
            chk32("busy_at_pulse", busy, 0);
            chk32("ready_at_pulse", instr_ready, 1);
        end
        prev_valid = regfile_valid;
    end

    // Track handshakes; acc_seen is the cycle index right after the accepting edge.
    always @(negedge clk12) begin
        if (instr_valid && instr_ready && !rst) begin
            acc_cnt++;
            acc_seen = cyc + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(posedge clk12);
            #1;
        end
    endtask

    task automatic do_accept(input logic [31:0] v, output int acc);
        int n;
        n = 0;
        @(negedge clk12);
        instr = v;
        instr_valid = 1'b1;
        while (!instr_ready && n < 1000) begin
            @(negedge clk12);
            n++;
        end
        chk32("accept_ready", instr_ready, 1);
        @(posedge clk12);
        #1;
        instr_valid = 1'b0;
        acc = cyc;
        @(negedge clk12);
        chk32("busy_after_accept", busy, 1);
        chk32("ready_after_accept", instr_ready, 0);
        chk32("tmo_cleared", timeout_err, 0);
        chk32("ferr_cleared", frame_err, 0);
    endtask

    task automatic check_tx(input logic [31:0] v, input int acc);
        int n;
        logic [7:0] eb;
        n = 0;
        while (txq.size() < 4 && n < 60 * CPB) begin
            @(negedge clk12);
            n++;
        end
        if (txq.size() < 4) begin
            chk32("tx_byte_count", txq.size(), 4);
        end else begin
            for (int k = 0; k < 4; k++) begin
                eb = 8'(v >> (8 * k));
                chk32($sformatf("tx_byte%0d", k), txq.pop_front(), eb);
                chk32($sformatf("tx_start%0d", k), txt.pop_front(), acc + k * 10 * CPB);
            end
            chk32("ready_low_in_send", instr_ready, 0);
        end
    endtask

    task automatic respond(input int n_good, input int bad_at, input bit pat_idx,
                           input bit exp_done, input bit exp_ferr);
        logic [1023:0] asm_v;
        logic [7:0]    b;
        int            vc;
        int            l;
        asm_v = model_rf;
        vc = valid_cnt;
        @(posedge clk12);
        #1;
        repeat ($urandom_range(0, 40)) begin @(posedge clk12); #1; end
        for (int k = 0; k < n_good; k++) begin
            if (k == bad_at) begin
                send_byte(8'($urandom), 1'b0);
                rx = 1'b1;
                repeat (CPB) begin @(posedge clk12); #1; end
            end
            if (k == 127) begin
                repeat (3 * CPB) begin @(posedge clk12); #1; end
                chk32("no_early_done", valid_cnt - vc, 0);
            end
            b = pat_idx ? ((k % 4 == 0) ? 8'(k / 4) : 8'h00) : 8'($urandom);
            asm_v[8*k +: 8] = b;
            repeat ($urandom_range(0, 3)) begin @(posedge clk12); #1; end
            send_byte(b, 1'b1);
        end
        l = cyc;
        if (exp_done) begin
            repeat (3 * CPB) @(negedge clk12);
            chk32("done_pulse", valid_cnt - vc, 1);
            model_rf = asm_v;
        end else begin
            while (cyc < l + TMO - 10) @(negedge clk12);
            chk32("tmo_not_yet", timeout_err, 0);
            while (cyc < l + TMO + 6) @(negedge clk12);
            chk32("tmo_set", timeout_err, 1);
            chk32("no_pulse_on_tmo", valid_cnt - vc, 0);
        end
        chk_rf("regfile", regfile_out, model_rf);
        chk32("frame_err", frame_err, exp_ferr);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        int ac0;

        vecs[0] = '{32'h00500093, 128, -1, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{$urandom, 10, -1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{$urandom, 128, 5, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{$urandom, 128, -1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{$urandom, 128, 0, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk12);
        @(negedge clk12);
        chk32("rst_ready", instr_ready, 0);
        chk32("rst_tx", tx, 1);
        chk32("rst_busy", busy, 0);
        chk32("rst_valid", regfile_valid, 0);
        chk32("rst_tmo", timeout_err, 0);
        chk32("rst_ferr", frame_err, 0);
        chk_rf("rst_regfile", regfile_out, '0);
        @(posedge clk12);
        #1;
        rst = 1'b0;
        @(posedge clk12);
        @(negedge clk12);
        chk32("ready_after_rst", instr_ready, 1);

        // Table of transactions
        for (int i = 0; i < 5; i++) begin
            do_accept(vecs[i].instr, acc);
            check_tx(vecs[i].instr, acc);
            respond(vecs[i].n_good, vecs[i].bad_at, vecs[i].pat_idx, vecs[i].exp_done, vecs[i].exp_ferr);
            if (vecs[i].pat_idx) begin
                chk32("x1", regfile_out[63:32], 32'd1);
                chk32("x31", regfile_out[1023:992], 32'd31);
            end
        end

        // Reset during SEND byte 2
        do_accept(32'h12345678, acc);
        while (cyc < acc + 2 * 10 * CPB + 10) @(posedge clk12);
        #1;
        rst = 1'b1;
        @(posedge clk12);
        @(negedge clk12);
        chk32("midrst_tx", tx, 1);
        chk32("midrst_busy", busy, 0);
        chk32("midrst_ready", instr_ready, 0);
        chk_rf("midrst_regfile", regfile_out, '0);
        model_rf = '0;
        @(posedge clk12);
        #1;
        rst = 1'b0;
        @(posedge clk12);
        @(negedge clk12);
        chk32("midrst_ready_after", instr_ready, 1);
        repeat (60) @(negedge clk12);
        txq.delete();
        txt.delete();
        repeat (300) @(negedge clk12);
        chk32("no_stale_tx", txq.size(), 0);

        // Request held during WAIT_RESP is taken only after completion
        do_accept(32'hA5C3_0F11, acc);
        check_tx(32'hA5C3_0F11, acc);
        instr = 32'hDEADBEEF;
        instr_valid = 1'b1;
        ac0 = acc_cnt;
        respond(128, -1, 1'b0, 1'b1, 1'b0);
        instr_valid = 1'b0;
        chk32("held_one_accept", acc_cnt - ac0, 1);
        check_tx(32'hDEADBEEF, acc_seen);
        repeat (TMO + 100) @(negedge clk12);
        chk32("held_no_extra_tx", txq.size(), 0);
        chk32("held_still_one", acc_cnt - ac0, 1);
        chk32("held_tmo", timeout_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
